mem_arbiter_rr: RTL and testbench
=================================

Name: mem_arbiter_rr

Overview:
- Two-master, one-slave arbiter for the picorv32 native memory interface (valid/ready/addr/wdata/wstrb/rdata).
- Shares one memory/MMIO port between the CPU (m0) and a second requester (m1), e.g. a DMA engine or a bench-side loader.
- Round-robin fairness; grant is locked for the whole transaction; a watchdog completes stalled transactions so the CPU never hangs on an unmapped address.

Parameters:
- TIMEOUT, 256: cycles a granted transaction may wait for s_ready before forced completion; 0 disables the watchdog.
- TIMEOUT_DATA, 32'hDEAD_BEEF: read data returned on forced completion.

Ports:
- clk  in  1  clock, all logic on posedge
- reset  in  1  synchronous, active-high reset
- m0_valid  in  1  master 0 request
- m0_instr  in  1  master 0 instruction-fetch flag
- m0_ready  out  1  master 0 completion strobe
- m0_addr  in  32  master 0 byte address
- m0_wdata  in  32  master 0 write data
- m0_wstrb  in  4  master 0 byte enables; 0 means read
- m0_rdata  out  32  master 0 read data
- m1_valid, m1_ready, m1_addr, m1_wdata, m1_wstrb, m1_rdata: same as m0, no instr flag
- s_valid  out  1  slave request
- s_instr  out  1  granted m0_instr; 0 when m1 is granted
- s_ready  in  1  slave completion
- s_addr  out  32  granted address
- s_wdata  out  32  granted write data
- s_wstrb  out  4  granted byte enables
- s_rdata  in  32  slave read data
- timeout  out  1  one-cycle pulse on forced completion
- timeout_addr  out  32  address of the last forced completion

Behaviour:
- Interface declaration: one clock, clk; reset is synchronous and active-high, named reset.
- States: IDLE, GRANT0, GRANT1. A state register and a last_grant bit.
- Reset values:
  - state = IDLE, last_grant = 1, so m0 wins the first tie.
  - wd_cnt = 0, timeout = 0, timeout_addr = 0.
  - s_valid = 0, m0_ready = 0, m1_ready = 0.
- IDLE arbitration:
  - Only one mx_valid high: go to GRANTx at the next edge.
  - Both high: grant the master that is not last_grant.
  - last_grant is updated on entry to GRANTx.
- GRANTx:
  - s_valid = 1.
  - s_addr, s_wdata, s_wstrb and s_instr are combinational muxes of master x's inputs.
  - In IDLE, s_valid = 0 and the s_* data outputs are 0.
- Completion:
  - In the cycle s_ready = 1, mx_ready = 1 combinationally and mx_rdata = s_rdata.
  - State returns to IDLE at that edge, so s_valid drops the next cycle.
- Latency: request seen in cycle N gives s_valid in N+1. Minimum transaction is 2 cycles. Back-to-back requests from one master have 1 IDLE cycle between grants.
- The ungranted master's ready is always 0. Both rdata outputs are driven from s_rdata; the mux may be shared and is valid only with ready.
- Watchdog (wd_cnt, $clog2(TIMEOUT+1) bits):
  - Cleared in IDLE; increments each GRANT cycle without s_ready.
  - When wd_cnt == TIMEOUT-1 and s_ready = 0: mx_ready = 1, mx_rdata = TIMEOUT_DATA.
  - Same cycle: timeout pulses, timeout_addr latches s_addr, and the state returns to IDLE.
  - s_valid drops next cycle. A late s_ready is ignored while IDLE.
- s_ready and watchdog expiry in the same cycle: s_ready wins, normal completion, no timeout pulse.
- TIMEOUT = 0: the watchdog never fires and wd_cnt stays 0.
- Granted master drops valid before completion (protocol violation):
  - Abandon the transaction: next state IDLE, no ready, wd_cnt cleared.
  - last_grant is kept.
- Reset asserted mid-transaction: all state returns to reset values at that edge. s_valid is 0 the following cycle; an in-flight s_ready is ignored.
- Writes and reads are treated identically; the arbiter never inspects addresses (MMIO decode stays downstream).

Test Plan:
- Single m0 read of addr 0x100, slave ready 2 cycles after s_valid, s_rdata = 0x12345678 -> m0_ready for exactly 1 cycle with m0_rdata = 0x12345678; s_instr follows m0_instr; m1_ready stays 0.
- m0 and m1 both valid continuously, slave ready on the first s_valid cycle -> grants alternate m0, m1, m0, m1; each transaction takes 2 cycles.
- m1 write addr 0x1000_0000, wdata 0x41, wstrb 4'b0001 -> s_addr/s_wdata/s_wstrb match and s_instr = 0 during the grant; completion on s_ready.
- TIMEOUT = 8, slave never ready, m0 reads 0x0001_FFF0 -> m0_ready in the 8th grant cycle with rdata 0xDEADBEEF; timeout pulses once; timeout_addr = 0x0001_FFF0.
- TIMEOUT = 8, s_ready arrives exactly in the 8th grant cycle -> normal data is returned and timeout stays 0.
- Reset asserted in GRANT1 mid-wait -> next cycle s_valid = 0 and state IDLE; after release, a simultaneous m0/m1 request grants m0 first.

Source files
------------

// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter sharing one picorv32 native memory port between two masters,
// with a watchdog that force-completes transactions the slave never acknowledges.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | no transaction in flight; arbitrate among pending requests
//   GRANT0 | m0 owns the slave port until s_ready, watchdog or abandon
//   GRANT1 | m1 owns the slave port until s_ready, watchdog or abandon
module mem_arbiter_rr #(
   parameter int unsigned TIMEOUT      = 256,
   parameter logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF
) (
   input  logic        clk,
   input  logic        reset,

   input  logic        m0_valid,
   input  logic        m0_instr,
   output logic        m0_ready,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_wstrb,
   output logic [31:0] m0_rdata,

   input  logic        m1_valid,
   output logic        m1_ready,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_wstrb,
   output logic [31:0] m1_rdata,

   output logic        s_valid,
   output logic        s_instr,
   input  logic        s_ready,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   output logic [3:0]  s_wstrb,
   input  logic [31:0] s_rdata,

   output logic        timeout,
   output logic [31:0] timeout_addr
);

   localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
   localparam bit WD_EN = (TIMEOUT != 0);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic            last_grant, last_grant_nxt;
   logic [WD_W-1:0] wd_cnt, wd_cnt_nxt;
   logic            gnt_valid;
   logic            expire;
   logic            done;
   logic [31:0]     rdata_mux;

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         last_grant   <= 1'b1;
         wd_cnt       <= '0;
         timeout_addr <= '0;
      end else begin
         state      <= state_nxt;
         last_grant <= last_grant_nxt;
         wd_cnt     <= wd_cnt_nxt;
         if (timeout) begin
            timeout_addr <= s_addr;
         end
      end
   end

   always_comb begin
      state_nxt      = state;
      last_grant_nxt = last_grant;
      wd_cnt_nxt     = '0;
      gnt_valid      = 1'b0;
      expire         = 1'b0;
      done           = 1'b0;
      s_valid        = 1'b0;
      s_instr        = 1'b0;
      s_addr         = '0;
      s_wdata        = '0;
      s_wstrb        = '0;

      case (state)
         IDLE: begin
            // last_grant resets to 1 so m0 wins the first tie
            if (m0_valid && (!m1_valid || last_grant)) begin
               state_nxt      = GRANT0;
               last_grant_nxt = 1'b0;
            end else if (m1_valid) begin
               state_nxt      = GRANT1;
               last_grant_nxt = 1'b1;
            end
         end
         GRANT0: begin
            s_valid   = 1'b1;
            s_instr   = m0_instr;
            s_addr    = m0_addr;
            s_wdata   = m0_wdata;
            s_wstrb   = m0_wstrb;
            gnt_valid = m0_valid;
         end
         GRANT1: begin
            s_valid   = 1'b1;
            s_addr    = m1_addr;
            s_wdata   = m1_wdata;
            s_wstrb   = m1_wstrb;
            gnt_valid = m1_valid;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      if (state != IDLE) begin
         // s_ready has priority over watchdog expiry in the same cycle
         expire = WD_EN && gnt_valid && !s_ready && (wd_cnt == WD_LAST);
         if (!gnt_valid) begin
            state_nxt = IDLE;
         end else if (s_ready || expire) begin
            done      = 1'b1;
            state_nxt = IDLE;
         end else if (WD_EN) begin
            wd_cnt_nxt = wd_cnt + WD_W'(1);
         end
      end
   end

   assign rdata_mux = expire ? TIMEOUT_DATA : s_rdata;
   assign m0_rdata  = rdata_mux;
   assign m1_rdata  = rdata_mux;
   assign m0_ready  = done && (state == GRANT0);
   assign m1_ready  = done && (state == GRANT1);
   assign timeout   = expire;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed bench for mem_arbiter_rr built with an 8-cycle watchdog.
module tb_mem_arbiter_rr;

   logic        clk = 1'b0;
   logic        reset;
   logic        m0_valid, m0_instr, m0_ready;
   logic [31:0] m0_addr, m0_wdata, m0_rdata;
   logic [3:0]  m0_wstrb;
   logic        m1_valid, m1_ready;
   logic [31:0] m1_addr, m1_wdata, m1_rdata;
   logic [3:0]  m1_wstrb;
   logic        s_valid, s_instr, s_ready;
   logic [31:0] s_addr, s_wdata, s_rdata;
   logic [3:0]  s_wstrb;
   logic        timeout;
   logic [31:0] timeout_addr;

   int errors = 0;
   int checks = 0;

   mem_arbiter_rr #(.TIMEOUT(8), .TIMEOUT_DATA(32'hDEAD_BEEF)) dut (
      .clk(clk), .reset(reset),
      .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_ready(m0_ready),
      .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata),
      .m1_valid(m1_valid), .m1_ready(m1_ready),
      .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata),
      .s_valid(s_valid), .s_instr(s_instr), .s_ready(s_ready),
      .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_rdata(s_rdata),
      .timeout(timeout), .timeout_addr(timeout_addr)
   );

   always #5 clk = ~clk;

   // inputs change 1 time unit after the rising edge; outputs settle well before the next one
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      m0_valid = 0; m0_instr = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
      m1_valid = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
      s_ready = 0; s_rdata = 0;
      tick(); tick();
      reset = 1'b0;
      #1;
      checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL reset_s_valid got %b exp 0", s_valid); end
      checks++; if ({m0_ready, m1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got %b exp 00", {m0_ready, m1_ready}); end
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b exp 0", timeout); end
      checks++; if (timeout_addr !== 32'h0) begin errors++; $display("FAIL reset_timeout_addr got %h exp 0", timeout_addr); end
   endtask

   task automatic test_single_read();
      m0_valid = 1; m0_instr = 1; m0_addr = 32'h100; m0_wstrb = 0;
      #1;
      checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL rd_req_cycle_s_valid got %b exp 0", s_valid); end
      tick();
      checks++; if (s_valid !== 1'b1 || s_addr !== 32'h100) begin errors++; $display("FAIL rd_grant got valid=%b addr=%h exp 1/00000100", s_valid, s_addr); end
      checks++; if (s_instr !== 1'b1) begin errors++; $display("FAIL rd_s_instr got %b exp 1", s_instr); end
      checks++; if (m0_ready !== 1'b0) begin errors++; $display("FAIL rd_early_ready got %b exp 0", m0_ready); end
      tick();
      checks++; if (m0_ready !== 1'b0) begin errors++; $display("FAIL rd_wait_ready got %b exp 0", m0_ready); end
      tick();
      s_ready = 1; s_rdata = 32'h1234_5678;
      #1;
      checks++; if (m0_ready !== 1'b1 || m0_rdata !== 32'h1234_5678) begin errors++; $display("FAIL rd_done got rdy=%b data=%h exp 1/12345678", m0_ready, m0_rdata); end
      checks++; if (m1_ready !== 1'b0) begin errors++; $display("FAIL rd_m1_ready got %b exp 0", m1_ready); end
      tick();
      m0_valid = 0; s_ready = 0; m0_instr = 0;
      #1;
      checks++; if (s_valid !== 1'b0 || m0_ready !== 1'b0) begin errors++; $display("FAIL rd_after got valid=%b rdy=%b exp 0/0", s_valid, m0_ready); end
   endtask

   // last grant was m0, so with both requesting the order is m1, m0, m1, m0
   task automatic test_back_to_back();
      logic [2:0] exp_seq [8];
      exp_seq = '{3'b000, 3'b110, 3'b000, 3'b101, 3'b000, 3'b110, 3'b000, 3'b101};
      m0_valid = 1; m0_addr = 32'hA0; m1_valid = 1; m1_addr = 32'hB0;
      s_ready = 1; s_rdata = 32'h5555_AAAA;
      for (int i = 0; i < 8; i++) begin
         #1;
         checks++;
         if ({s_valid, m1_ready, m0_ready} !== exp_seq[i]) begin
            errors++; $display("FAIL b2b_cycle%0d got v/r1/r0=%b exp %b", i, {s_valid, m1_ready, m0_ready}, exp_seq[i]);
         end
         if (exp_seq[i][0]) begin
            checks++; if (s_addr !== 32'hA0) begin errors++; $display("FAIL b2b_addr0 cycle%0d got %h exp a0", i, s_addr); end
         end
         if (exp_seq[i][1]) begin
            checks++; if (s_addr !== 32'hB0) begin errors++; $display("FAIL b2b_addr1 cycle%0d got %h exp b0", i, s_addr); end
         end
         tick();
      end
      m0_valid = 0; m1_valid = 0; s_ready = 0;
   endtask

   task automatic test_m1_write();
      m1_valid = 1; m1_addr = 32'h1000_0000; m1_wdata = 32'h41; m1_wstrb = 4'b0001;
      m0_instr = 1;
      #1;
      checks++; if (s_wstrb !== 4'b0000) begin errors++; $display("FAIL wr_idle_wstrb got %b exp 0000", s_wstrb); end
      tick();
      checks++; if (s_addr !== 32'h1000_0000 || s_wdata !== 32'h41 || s_wstrb !== 4'b0001) begin
         errors++; $display("FAIL wr_mux got %h/%h/%b exp 10000000/00000041/0001", s_addr, s_wdata, s_wstrb); end
      checks++; if (s_instr !== 1'b0) begin errors++; $display("FAIL wr_s_instr got %b exp 0", s_instr); end
      tick();
      s_ready = 1;
      #1;
      checks++; if (m1_ready !== 1'b1 || m0_ready !== 1'b0) begin errors++; $display("FAIL wr_done got r1=%b r0=%b exp 1/0", m1_ready, m0_ready); end
      tick();
      m1_valid = 0; s_ready = 0; m0_instr = 0;
   endtask

   task automatic test_timeout();
      m0_valid = 1; m0_addr = 32'h0001_FFF0; m0_wstrb = 0; s_rdata = 32'h0;
      tick();
      for (int k = 1; k < 8; k++) begin
         checks++; if (m0_ready !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL to_early cycle%0d got rdy=%b to=%b exp 0/0", k, m0_ready, timeout); end
         tick();
      end
      checks++; if (m0_ready !== 1'b1 || m0_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL to_fire got rdy=%b data=%h exp 1/deadbeef", m0_ready, m0_rdata); end
      checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_pulse got %b exp 1", timeout); end
      tick();
      m0_valid = 0; s_ready = 1;
      #1;
      checks++; if (timeout !== 1'b0 || s_valid !== 1'b0) begin errors++; $display("FAIL to_after got to=%b valid=%b exp 0/0", timeout, s_valid); end
      checks++; if (timeout_addr !== 32'h0001_FFF0) begin errors++; $display("FAIL to_addr got %h exp 0001fff0", timeout_addr); end
      checks++; if (m0_ready !== 1'b0) begin errors++; $display("FAIL to_late_ready got %b exp 0", m0_ready); end
      tick();
      s_ready = 0;
   endtask

   task automatic test_ready_wins();
      m0_valid = 1; m0_addr = 32'h2000;
      tick();
      for (int k = 1; k < 8; k++) tick();
      s_ready = 1; s_rdata = 32'hCAFE_F00D;
      #1;
      checks++; if (m0_ready !== 1'b1 || m0_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL race_data got rdy=%b data=%h exp 1/cafef00d", m0_ready, m0_rdata); end
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL race_timeout got %b exp 0", timeout); end
      tick();
      m0_valid = 0; s_ready = 0;
      #1;
      checks++; if (timeout_addr !== 32'h0001_FFF0) begin errors++; $display("FAIL race_addr_kept got %h exp 0001fff0", timeout_addr); end
   endtask

   task automatic test_abandon();
      m1_valid = 1; m1_addr = 32'h300;
      tick();
      tick();
      m1_valid = 0;
      #1;
      checks++; if (m1_ready !== 1'b0) begin errors++; $display("FAIL abandon_ready got %b exp 0", m1_ready); end
      tick();
      checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL abandon_idle got %b exp 0", s_valid); end
   endtask

   task automatic test_reset_mid();
      m1_valid = 1; m1_addr = 32'h400;
      tick();
      tick();
      checks++; if (s_valid !== 1'b1 || s_addr !== 32'h400) begin errors++; $display("FAIL rst_pre got valid=%b addr=%h exp 1/00000400", s_valid, s_addr); end
      reset = 1;
      tick();
      reset = 0; m0_valid = 1; m0_addr = 32'h500; s_ready = 1;
      #1;
      checks++; if (s_valid !== 1'b0 || m1_ready !== 1'b0) begin errors++; $display("FAIL rst_idle got valid=%b r1=%b exp 0/0", s_valid, m1_ready); end
      tick();
      checks++; if (s_addr !== 32'h500 || m0_ready !== 1'b1 || m1_ready !== 1'b0) begin
         errors++; $display("FAIL rst_first_grant got addr=%h r0=%b r1=%b exp 00000500/1/0", s_addr, m0_ready, m1_ready); end
      tick();
      m0_valid = 0;
      tick();
      checks++; if (s_addr !== 32'h400 || m1_ready !== 1'b1) begin errors++; $display("FAIL rst_second_grant got addr=%h r1=%b exp 00000400/1", s_addr, m1_ready); end
      tick();
      m1_valid = 0; s_ready = 0;
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_back_to_back();
      test_m1_write();
      test_timeout();
      test_ready_wins();
      test_abandon();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
